// File: rtl/seven_seg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seven_seg_pkg : shared types, constants and glyph table            |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic [3:0] nibble;
    logic       dp;
    logic       blank;
    logic       blink;
  } digit_rec_t;

  localparam digit_rec_t DIGIT_OFF = '{nibble: 4'h0, dp: 1'b0, blank: 1'b1, blink: 1'b0};

  // Active-low segments, bit order gfedcba.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    s = SEG_BLANK;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_glyph.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seven_seg_glyph : combinational hex nibble to segment decoder      |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
module seven_seg_glyph (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  import seven_seg_pkg::*;

  assign seg = hex_to_seg(nibble);

endmodule
`default_nettype wire

// File: rtl/seven_seg_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seven_seg_mux : scanned N-digit display driver with PWM and blink  |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module seven_seg_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BRIGHT_W     = 4,
  parameter int GUARD        = 64,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic [NUM_DIGITS-1:0]   blink_i,
  input  logic                    update_i,
  input  logic [BRIGHT_W-1:0]     brightness_i,
  output logic                    pending_o,
  output logic                    frame_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic [6:0]              seg_o,
  output logic                    dp_o
);
  import seven_seg_pkg::*;

  localparam int PC_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BF_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BF_W-1:0]  BF_LAST  = BF_W'(BLINK_FRAMES - 1);
  localparam logic [31:0]      SLOT     = 32'(REFRESH_DIV >> BRIGHT_W);
  localparam logic [31:0]      GUARD_U  = 32'(GUARD);

  logic [PC_W-1:0]     r_pc;
  logic [IDX_W-1:0]    r_idx;
  logic [BF_W-1:0]     r_fcnt;
  logic                r_phase;
  logic                r_pending;
  logic [BRIGHT_W-1:0] r_bright;

  digit_rec_t [NUM_DIGITS-1:0] r_stage;
  digit_rec_t [NUM_DIGITS-1:0] r_shadow;
  digit_rec_t [NUM_DIGITS-1:0] w_in;
  digit_rec_t                  w_cur;

  logic                  w_slot_end;
  logic                  w_boundary;
  logic [BRIGHT_W-1:0]   w_bright;
  logic [31:0]           w_thresh;
  logic                  w_lit;
  logic [6:0]            w_glyph;
  logic [NUM_DIGITS-1:0] w_onehot;

  generate
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_pack
      assign w_in[k] = '{nibble: digits_i[4*k +: 4], dp: dp_i[k],
                         blank: blank_i[k], blink: blink_i[k]};
    end
  endgenerate

  assign w_slot_end = (r_pc == PC_LAST);
  assign w_boundary = w_slot_end && (r_idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= '0;
      r_idx    <= '0;
      r_fcnt   <= '0;
      r_phase  <= 1'b0;
      r_bright <= '0;
    end else begin
      if (r_pc == '0) r_bright <= brightness_i;
      if (w_slot_end) begin
        r_pc  <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_pc <= r_pc + 1'b1;
      end
      if (w_boundary) begin
        if (r_fcnt == BF_LAST) begin
          r_fcnt  <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_fcnt <= r_fcnt + 1'b1;
        end
      end
    end
  end

  // Shadow only changes on the frame boundary so a frame never mixes data sets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage   <= {NUM_DIGITS{DIGIT_OFF}};
      r_shadow  <= {NUM_DIGITS{DIGIT_OFF}};
      r_pending <= 1'b0;
    end else begin
      if (w_boundary && r_pending) r_shadow <= r_stage;
      if (update_i) r_stage <= w_in;
      r_pending <= update_i | (r_pending & ~w_boundary);
    end
  end

  assign pending_o = r_pending;

  // The slot's first cycle uses the live brightness, matching what gets latched.
  assign w_bright = (r_pc == '0) ? brightness_i : r_bright;
  assign w_thresh = (32'(w_bright) + 32'd1) * SLOT;
  assign w_cur    = r_shadow[r_idx];
  assign w_lit    = (32'(r_pc) >= GUARD_U) && (32'(r_pc) < w_thresh) &&
                    !w_cur.blank && !(w_cur.blink && r_phase);

  always_comb begin
    w_onehot        = '0;
    w_onehot[r_idx] = 1'b1;
  end

  seven_seg_glyph u_glyph (
    .nibble (w_cur.nibble),
    .seg    (w_glyph)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_o    <= '1;
      seg_o   <= SEG_BLANK;
      dp_o    <= 1'b1;
      frame_o <= 1'b0;
    end else begin
      frame_o <= (r_pc == '0) && (r_idx == '0);
      if (w_lit) begin
        an_o  <= ~w_onehot;
        seg_o <= w_glyph;
        dp_o  <= ~w_cur.dp;
      end else begin
        an_o  <= '1;
        seg_o <= SEG_BLANK;
        dp_o  <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_seven_seg_mux : randomized bench with a time-indexed display model |
// | Revision         : 1.0                                             |
// +--------------------------------------------------------------------+
module tb_seven_seg_mux;
  localparam int ND = 4, RD = 16, BW = 2, GD = 1, BF = 2;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [15:0] digits_i = '0;
  logic [3:0]  dp_i = '0, blank_i = '0, blink_i = '0;
  logic        update_i = 1'b0;
  logic [1:0]  brightness_i = '0;
  logic        pending_o, frame_o, dp_o;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  seven_seg_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BRIGHT_W(BW), .GUARD(GD),
                  .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .digits_i(digits_i), .dp_i(dp_i), .blank_i(blank_i),
    .blink_i(blink_i), .update_i(update_i), .brightness_i(brightness_i),
    .pending_o(pending_o), .frame_o(frame_o), .an_o(an_o), .seg_o(seg_o), .dp_o(dp_o)
  );

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: display state is a pure function of cycles elapsed since reset (t).
  int          t, bslot, m_pc, m_idx;
  bit          m_ph, m_lit, mpend;
  logic [15:0] st_dig, sh_dig;
  logic [3:0]  st_dp, st_bl, st_bk, sh_dp, sh_bl, sh_bk;
  logic [13:0] exp_vec;
  localparam logic [13:0] DARK = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0};

  function automatic logic [13:0] obs();
    return {an_o, seg_o, dp_o, frame_o, pending_o};
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        t = 0; bslot = 0; mpend = 1'b0;
        st_dig = '0; st_dp = '0; st_bl = '1; st_bk = '0;
        sh_dig = '0; sh_dp = '0; sh_bl = '1; sh_bk = '0;
        exp_vec = DARK;
      end else begin
        m_pc  = t % RD;
        m_idx = (t / RD) % ND;
        m_ph  = (((t / FRAME) / BF) % 2) == 1;
        if (m_pc == 0) bslot = int'(brightness_i);
        m_lit = (m_pc >= GD) && (m_pc < (bslot + 1) * (RD >> BW)) &&
                !sh_bl[m_idx] && !(sh_bk[m_idx] && m_ph);
        if (m_lit) exp_vec[13:2] = {~(4'b0001 << m_idx), glyph[sh_dig[4*m_idx +: 4]], ~sh_dp[m_idx]};
        else       exp_vec[13:2] = {4'hF, 7'h7F, 1'b1};
        exp_vec[1] = (t % FRAME == 0);
        if ((t % FRAME == FRAME - 1) && mpend) begin
          sh_dig = st_dig; sh_dp = st_dp; sh_bl = st_bl; sh_bk = st_bk; mpend = 1'b0;
        end
        if (update_i) begin
          st_dig = digits_i; st_dp = dp_i; st_bl = blank_i; st_bk = blink_i; mpend = 1'b1;
        end
        exp_vec[0] = mpend;
        t++;
      end
    end
  end

  task automatic test_reset();
    int frames = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs() !== DARK) begin
      errors++; $display("FAIL reset_state: got %h expected %h", obs(), DARK);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_vec) begin
        errors++; $display("FAIL reset_idle cyc %0d: got %h expected %h", i, obs(), exp_vec);
      end
      if (frame_o === 1'b1) frames++;
    end
    checks++;
    if (frames !== 4) begin
      errors++; $display("FAIL reset_frame_count: got %0d expected 4", frames);
    end
  endtask

  task automatic test_display();
    int lit = 0;
    @(negedge clk);
    digits_i = 16'hF810; dp_i = 4'b0001; blank_i = '0; blink_i = '0;
    brightness_i = 2'd3; update_i = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      update_i = 1'b0;
      checks++;
      if (obs() !== exp_vec) begin
        errors++; $display("FAIL display cyc %0d: got %h expected %h", i, obs(), exp_vec);
      end
      if (i >= 2 * FRAME) begin
        if (an_o !== 4'hF) lit++;
        if (an_o === 4'b1110) begin
          checks++;
          if (seg_o !== 7'h40 || dp_o !== 1'b0) begin
            errors++; $display("FAIL display_d0: got seg %h dp %b expected 40 0", seg_o, dp_o);
          end
        end
        if (an_o === 4'b1011) begin
          checks++;
          if (seg_o !== 7'h00 || dp_o !== 1'b1) begin
            errors++; $display("FAIL display_d2: got seg %h dp %b expected 00 1", seg_o, dp_o);
          end
        end
      end
    end
    checks++;
    if (lit !== 60) begin
      errors++; $display("FAIL display_duty: got %0d lit expected 60", lit);
    end
  endtask

  task automatic test_brightness();
    int lit = 0;
    brightness_i = 2'd0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_vec) begin
        errors++; $display("FAIL bright0 cyc %0d: got %h expected %h", i, obs(), exp_vec);
      end
      if (i >= 2 * FRAME && an_o !== 4'hF) lit++;
    end
    checks++;
    if (lit !== 12) begin
      errors++; $display("FAIL bright0_duty: got %0d lit expected 12", lit);
    end
    while (t % RD != 6) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_vec) begin
        errors++; $display("FAIL bright_wait: got %h expected %h", obs(), exp_vec);
      end
    end
    brightness_i = 2'd2;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_vec) begin
        errors++; $display("FAIL bright_change cyc %0d: got %h expected %h", i, obs(), exp_vec);
      end
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    brightness_i = 2'd3;
    while (t % FRAME != 10) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_vec) begin
        errors++; $display("FAIL b2b_wait: got %h expected %h", obs(), exp_vec);
      end
    end
    for (int i = 0; i < 2 * FRAME + 10; i++) begin
      if (i == 0)  begin digits_i = 16'h1111; dp_i = '0; blank_i = '0; blink_i = '0; update_i = 1'b1; end
      if (i == 10) begin digits_i = 16'hAAAA; update_i = 1'b1; end
      @(negedge clk);
      update_i = 1'b0;
      checks++;
      if (obs() !== exp_vec) begin
        errors++; $display("FAIL b2b cyc %0d: got %h expected %h", i, obs(), exp_vec);
      end
      if (i >= FRAME && an_o !== 4'hF && seg_o !== 7'h08) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL b2b_last_wins: got %0d wrong glyphs expected 0", bad);
    end
    while (t % FRAME != 30) @(negedge clk);
    digits_i = 16'h2345; update_i = 1'b1;
    @(negedge clk);
    update_i = 1'b0;
    while (t % FRAME != FRAME - 1) @(negedge clk);
    digits_i = 16'h6789; update_i = 1'b1;
    @(negedge clk);
    update_i = 1'b0;
    checks++;
    if (pending_o !== 1'b1) begin
      errors++; $display("FAIL boundary_pending: got %b expected 1", pending_o);
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_vec) begin
        errors++; $display("FAIL boundary cyc %0d: got %h expected %h", i, obs(), exp_vec);
      end
    end
  endtask

  task automatic test_blink();
    int d2 = 0, d0 = 0;
    @(negedge clk);
    digits_i = 16'h1234; dp_i = 4'b1010; blank_i = '0; blink_i = 4'b0100; update_i = 1'b1;
    for (int i = 0; i < 6 * FRAME; i++) begin
      @(negedge clk);
      update_i = 1'b0;
      checks++;
      if (obs() !== exp_vec) begin
        errors++; $display("FAIL blink cyc %0d: got %h expected %h", i, obs(), exp_vec);
      end
      if (i >= 2 * FRAME && an_o === 4'b1011) d2++;
      if (i >= 2 * FRAME && an_o === 4'b1110) d0++;
    end
    checks++;
    if (d2 !== 30 || d0 !== 60) begin
      errors++; $display("FAIL blink_duty: got d2=%0d d0=%0d expected 30 60", d2, d0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_vec) begin
        errors++; $display("FAIL random cyc %0d: got %h expected %h", i, obs(), exp_vec);
      end
      update_i = 1'b0;
      if ($urandom_range(0, 39) == 0) begin
        digits_i = 16'($urandom); dp_i = 4'($urandom); blank_i = 4'($urandom);
        blink_i = 4'($urandom); update_i = 1'b1;
      end
      if ($urandom_range(0, 29) == 0) brightness_i = 2'($urandom);
    end
    update_i = 1'b0;
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    int lit = 0;
    digits_i = 16'h9876; dp_i = '0; blank_i = '0; blink_i = '0; brightness_i = 2'd3; update_i = 1'b1;
    @(negedge clk);
    update_i = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) @(negedge clk);
    while (t % FRAME != 20) @(negedge clk);
    digits_i = 16'h5555; update_i = 1'b1;
    @(negedge clk);
    update_i = 1'b0;
    for (int i = 0; i < RD && !found; i++) begin
      @(negedge clk);
      if (an_o !== 4'hF) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL areset_find_lit: got no lit cycle expected one within %0d", RD);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== DARK) begin
      errors++; $display("FAIL areset_immediate: got %h expected %h", obs(), DARK);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_vec) begin
        errors++; $display("FAIL areset_after cyc %0d: got %h expected %h", i, obs(), exp_vec);
      end
      if (an_o !== 4'hF || pending_o !== 1'b0) lit++;
    end
    checks++;
    if (lit !== 0) begin
      errors++; $display("FAIL areset_blank: got %0d active cycles expected 0", lit);
    end
  endtask

  initial begin
    test_reset();
    test_display();
    test_brightness();
    test_back_to_back();
    test_blink();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
